fetch_line_server: RTL and testbench
====================================

// Module: fetch_line_server
// PURPOSE
// - Instruction-memory responder for the fetch stage: supplies the 128-bit line (4 insns) containing pc as idata.
// - Holds one line buffer; on a miss, reads the line from a 32-bit backing memory, one word per handshake, and raises idata_valid when done.
// - Sits between the fetch stage (pc/idata) and the memory port. The fetch stage stalls while idata_valid=0.
// PARAMETERS
// - ADDR_W  32  fetch/memory byte-address width (`ADDR_LEN)
// - INSN_W  32  instruction/memory word width (`INSN_LEN); line = 4*INSN_W
// PORTS
// - clk            in   1         clock; all state updates on rising edge
// - reset          in   1         synchronous, active-high reset
// - pc             in   ADDR_W    fetch address; line tag = pc[ADDR_W-1:4]
// - fetch_req      in   1         fetch stage wants the line for pc this cycle
// - flush          in   1         invalidate line buffer (fence.i / imem rewrite)
// - idata          out  4*INSN_W  buffered line; word k at idata[32k+:32]
// - idata_valid    out  1         comb: buf_valid && buf_tag==pc[ADDR_W-1:4]
// - mem_req_valid  out  1         word read request
// - mem_req_addr   out  ADDR_W    {miss_tag, word_idx[1:0], 2'b00}
// - mem_req_ready  in   1         memory accepts request when valid&&ready
// - mem_rsp_valid  in   1         read data valid (>=1 cycle after acceptance)
// - mem_rsp_data   in   INSN_W    read data, in request order
// - hit_cnt        out  32        [FETCH_LINE_STATS_EN only] hit counter
// - miss_cnt       out  32        [FETCH_LINE_STATS_EN only] fill counter
// BEHAVIOUR
// - Reset: state=IDLE, buf_valid=0, buf_tag=0, idata=0, word_idx=0, kill=0, mem_req_valid=0, counters=0.
// - FSM IDLE: fetch_req && !idata_valid && !flush -> latch miss_tag=pc[ADDR_W-1:4], word_idx=0, kill=0 -> REQ.
// - FSM REQ: mem_req_valid=1, addr held stable; on mem_req_ready -> WAIT. No other request outstanding.
// - FSM WAIT: on mem_rsp_valid write mem_rsp_data into idata word word_idx; if word_idx==3 -> IDLE, buf_tag=miss_tag, buf_valid=!kill && !flush; else word_idx++ -> REQ.
// - mem_rsp_valid outside WAIT is ignored (no state change, no data write).
// - buf_valid is cleared when the first word of a fill is written (partial line is never reported valid).
// - Latency: miss seen in cycle 0, ready=1, response 1 cycle after accept -> idata_valid=1 in cycle 9.
// - Hit: idata_valid same cycle as pc, zero added latency; no memory traffic.
// - pc changes mid-fill: fill runs to completion for miss_tag; then idata_valid is re-evaluated vs new pc (may miss again).
// - flush in IDLE: buf_valid<=0 next cycle; a miss is not started in the flush cycle.
// - flush during REQ/WAIT: set kill; fill completes (protocol never abandoned), line stored with buf_valid=0.
// - flush in same cycle as last response: flush wins, buf_valid=0.
// - reset mid-fill: immediate return to IDLE, mem_req_valid=0 next cycle; later responses are dropped (arrive in IDLE).
// - Address wrap: miss_tag all-ones -> addresses ..F0..FC, no carry into other fields.
// CONFIGURATION
// - FETCH_LINE_STATS_EN defined: hit_cnt/miss_cnt ports exist.
//   - hit_cnt +1 each cycle fetch_req && idata_valid; miss_cnt +1 on each IDLE->REQ.
//   - Both saturate at 32'hFFFF_FFFF; cleared by reset only; flush does not clear.
// - Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - Cold miss pc=0x100, ready=1, rsp 1 cycle later with 0xA0..0xA3 -> addrs 0x100,104,108,10C; idata={A3,A2,A1,A0}; valid cycle 9.
// - Hit after fill: pc=0x108 -> idata_valid=1 same cycle, mem_req_valid stays 0 for 10 cycles.
// - Backpressure: ready=0 for 5 cycles on word 2 -> mem_req_valid, addr=0x108 held steady; line still correct.
// - flush in WAIT of word 1 -> fill completes, idata_valid=0 after; same pc refetches (miss_cnt=2 with STATS_EN).
// - Reset asserted in WAIT of word 2, stray rsp next cycle -> state IDLE, buf_valid=0, idata=0, no write.
// - pc switches 0x100->0x200 mid-fill -> first fill completes for 0x100, second fill at 0x200 starts next IDLE cycle.

Source files
------------

// File: rtl/fetch_line_server.sv
// Single-line instruction buffer for the fetch stage: serves 128-bit lines on hit,
// refills word-by-word from a 32-bit memory port on miss. Optional counters: FETCH_LINE_STATS_EN.
module fetch_line_server #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INSN_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   pc,
   input  logic                fetch_req,
   input  logic                flush,
   output logic [4*INSN_W-1:0] idata,
   output logic                idata_valid,
   output logic                mem_req_valid,
   output logic [ADDR_W-1:0]   mem_req_addr,
   input  logic                mem_req_ready,
   input  logic                mem_rsp_valid,
   input  logic [INSN_W-1:0]   mem_rsp_data
`ifdef FETCH_LINE_STATS_EN
   ,
   output logic [31:0]         hit_cnt,
   output logic [31:0]         miss_cnt
`endif
);

   localparam int unsigned TAG_W  = ADDR_W - 4;
   localparam int unsigned LINE_W = 4 * INSN_W;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic                buf_valid_q, buf_valid_d;
   logic [TAG_W-1:0]    buf_tag_q, buf_tag_d;
   logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
   logic [LINE_W-1:0]   idata_q, idata_d;
   logic [1:0]          word_idx_q, word_idx_d;
   logic                kill_q, kill_d;
   logic [TAG_W-1:0]    pc_tag;
   logic                start_miss;
   logic                unused_pc_offset;

   assign pc_tag           = pc[ADDR_W-1:4];
   assign unused_pc_offset = ^pc[3:0];
   assign idata_valid      = buf_valid_q && (buf_tag_q == pc_tag);
   assign start_miss       = (state_q == S_IDLE) && fetch_req && !idata_valid && !flush;
   assign mem_req_valid    = (state_q == S_REQ);
   assign mem_req_addr     = {miss_tag_q, word_idx_q, 2'b00};
   assign idata            = idata_q;

   // State and buffer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         miss_tag_q  <= '0;
         idata_q     <= '0;
         word_idx_q  <= 2'd0;
         kill_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         miss_tag_q  <= miss_tag_d;
         idata_q     <= idata_d;
         word_idx_q  <= word_idx_d;
         kill_q      <= kill_d;
      end
   end

   // Next-state: a started fill always runs to its fourth word; flush only poisons the result
   always_comb begin
      state_d     = state_q;
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      miss_tag_d  = miss_tag_q;
      idata_d     = idata_q;
      word_idx_d  = word_idx_q;
      kill_d      = kill_q;

      if (flush) buf_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_miss) begin
               miss_tag_d = pc_tag;
               word_idx_d = 2'd0;
               kill_d     = 1'b0;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (flush) kill_d = 1'b1;
            if (mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flush) kill_d = 1'b1;
            if (mem_rsp_valid) begin
               for (int k = 0; k < 4; k++) begin
                  if (word_idx_q == 2'(k)) idata_d[k*INSN_W +: INSN_W] = mem_rsp_data;
               end
               if (word_idx_q == 2'd0) buf_valid_d = 1'b0;
               if (word_idx_q == 2'd3) begin
                  state_d     = S_IDLE;
                  buf_tag_d   = miss_tag_q;
                  buf_valid_d = !kill_q && !flush;
               end else begin
                  word_idx_d = word_idx_q + 2'd1;
                  state_d    = S_REQ;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef FETCH_LINE_STATS_EN
   // Saturating hit / fill counters, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt  <= 32'd0;
         miss_cnt <= 32'd0;
      end else begin
         if (fetch_req && idata_valid && (hit_cnt != 32'hFFFF_FFFF)) hit_cnt <= hit_cnt + 32'd1;
         if (start_miss && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_line_server.sv
// Directed bench for fetch_line_server: fills, hits, backpressure, flush, reset and wrap cases.
module tb_fetch_line_server;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   pc;
   logic          fetch_req;
   logic          flush;
   logic [127:0]  idata;
   logic          idata_valid;
   logic          mem_req_valid;
   logic [31:0]   mem_req_addr;
   logic          mem_req_ready;
   logic          mem_rsp_valid;
   logic [31:0]   mem_rsp_data;
`ifdef FETCH_LINE_STATS_EN
   logic [31:0]   hit_cnt;
   logic [31:0]   miss_cnt;
`endif

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [31:0]   addr_q[$];

   always #5 clk = ~clk;

   fetch_line_server dut (
      .clk           (clk),
      .reset         (reset),
      .pc            (pc),
      .fetch_req     (fetch_req),
      .flush         (flush),
      .idata         (idata),
      .idata_valid   (idata_valid),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data)
`ifdef FETCH_LINE_STATS_EN
      ,
      .hit_cnt       (hit_cnt),
      .miss_cnt      (miss_cnt)
`endif
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Backing memory contents; line 0x100 holds A0..A3
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:4] == 28'h10) return 32'hA0 + {30'd0, a[3:2]};
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [127:0] line_of(input logic [31:0] a);
      logic [31:0] b;
      b = {a[31:4], 4'h0};
      return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
   endfunction

   // One clock; memory answers an accepted request one cycle later. Ends at negedge + 1.
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      acc = mem_req_valid && mem_req_ready;
      a   = mem_req_addr;
      if (acc) addr_q.push_back(a);
      @(posedge clk);
      @(negedge clk);
      mem_rsp_valid = acc;
      mem_rsp_data  = acc ? mem_word(a) : 32'h0;
      #1;
   endtask

   task automatic check_addrs(input string tag, input logic [31:0] base);
      logic [31:0] a;
      for (int i = 0; i < 4; i++) begin
         a = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hDEAD_DEAD;
         check(tag, 128'(a), 128'(base + 32'(4 * i)));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hits;
      reset = 1'b1; pc = 32'h0; fetch_req = 1'b0; flush = 1'b0;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
      @(negedge clk); #1;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      check("rst_idata", idata, 128'h0);
      check("rst_valid", 128'(idata_valid), 128'd0);
      check("rst_req", 128'(mem_req_valid), 128'd0);

      // Cold miss at 0x100
      pc = 32'h100; fetch_req = 1'b1; #1;
      check("cold_c0_valid", 128'(idata_valid), 128'd0);
      tick();
      check("cold_c1_req", 128'(mem_req_valid), 128'd1);
      check("cold_c1_addr", 128'(mem_req_addr), 128'h100);
      repeat (7) tick();
      check("cold_c8_valid", 128'(idata_valid), 128'd0);
      tick();
      check("cold_c9_valid", 128'(idata_valid), 128'd1);
      check("cold_idata", idata, 128'h000000A3_000000A2_000000A1_000000A0);
      check_addrs("cold_addr", 32'h100);

      // Hit in the same line: no memory traffic
      pc = 32'h108; #1;
      check("hit_valid", 128'(idata_valid), 128'd1);
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_req_valid) hits++;
      end
      check("hit_no_req", 128'(hits), 128'd0);
      check("hit_no_accept", 128'(addr_q.size()), 128'd0);

      // Flush in IDLE, then refill 0x100 with word 2 stalled 5 cycles
      pc = 32'h100; flush = 1'b1; #1;
      tick();
      flush = 1'b0; #1;
      check("flush_idle_valid", 128'(idata_valid), 128'd0);
      check("flush_idle_noreq", 128'(mem_req_valid), 128'd0);
      repeat (5) tick();
      check("bp_c5_req", 128'(mem_req_valid), 128'd1);
      check("bp_c5_addr", 128'(mem_req_addr), 128'h108);
      mem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_req", 128'(mem_req_valid), 128'd1);
         check("bp_hold_addr", 128'(mem_req_addr), 128'h108);
      end
      mem_req_ready = 1'b1;
      repeat (3) tick();
      check("bp_c13_valid", 128'(idata_valid), 128'd0);
      tick();
      check("bp_c14_valid", 128'(idata_valid), 128'd1);
      check("bp_idata", idata, 128'h000000A3_000000A2_000000A1_000000A0);
      check_addrs("bp_addr", 32'h100);

      // Flush in WAIT of word 1: line lands but stays invalid, same pc refetches
      pc = 32'h400; #1;
      repeat (4) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0; #1;
      repeat (4) tick();
      check("killw1_valid", 128'(idata_valid), 128'd0);
      check("killw1_idle", 128'(mem_req_valid), 128'd0);
      check("killw1_idata", idata, line_of(32'h400));
      tick();
      check("killw1_refetch", 128'(mem_req_valid), 128'd1);
      check("killw1_ref_addr", 128'(mem_req_addr), 128'h400);
      repeat (8) tick();
      check("killw1_refill", 128'(idata_valid), 128'd1);
      check_addrs("killw1_addr_a", 32'h400);
      check_addrs("killw1_addr_b", 32'h400);

      // pc moves 0x100 -> 0x200 mid-fill
      pc = 32'h100; #1;
      repeat (3) tick();
      pc = 32'h200; #1;
      repeat (6) tick();
      check("pcsw_c9_valid", 128'(idata_valid), 128'd0);
      check("pcsw_c9_idle", 128'(mem_req_valid), 128'd0);
      check("pcsw_c9_idata", idata, line_of(32'h100));
      tick();
      check("pcsw_c10_addr", 128'(mem_req_addr), 128'h200);
      repeat (8) tick();
      check("pcsw_valid", 128'(idata_valid), 128'd1);
      check("pcsw_idata", idata, line_of(32'h200));
      check_addrs("pcsw_addr_a", 32'h100);
      check_addrs("pcsw_addr_b", 32'h200);

      // Flush coinciding with the last response
      pc = 32'h600; #1;
      repeat (8) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0; fetch_req = 1'b0; #1;
      check("killlast_valid", 128'(idata_valid), 128'd0);
      check("killlast_idata", idata, line_of(32'h600));
      tick();
      check("killlast_noreq", 128'(mem_req_valid), 128'd0);
      check_addrs("killlast_addr", 32'h600);

      // Tag all-ones: word index must not carry
      pc = 32'hFFFF_FFF4; fetch_req = 1'b1; #1;
      repeat (9) tick();
      check("wrap_valid", 128'(idata_valid), 128'd1);
      check("wrap_idata", idata, line_of(32'hFFFF_FFF0));
      check_addrs("wrap_addr", 32'hFFFF_FFF0);
`ifdef FETCH_LINE_STATS_EN
      check("stats_miss", 128'(miss_cnt), 128'd8);
`endif

      // Reset in WAIT of word 2, then a stray response
      pc = 32'h500; #1;
      repeat (6) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; fetch_req = 1'b0; pc = 32'h0;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF; #1;
      check("rst_mid_req", 128'(mem_req_valid), 128'd0);
      check("rst_mid_idata", idata, 128'h0);
      check("rst_mid_valid", 128'(idata_valid), 128'd0);
      tick();
      check("stray_idata", idata, 128'h0);
      check("stray_req", 128'(mem_req_valid), 128'd0);
      check("stray_valid", 128'(idata_valid), 128'd0);
`ifdef FETCH_LINE_STATS_EN
      check("stats_rst", 128'(miss_cnt), 128'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
